// File: rtl/gray_run_ctrl.sv
// Run/step/stop sequencer for gray_Nbits: turns raw button levels into a prescaled
// or single-step clk_en stream and halts automatically when the counter reaches a binary target.
module gray_run_ctrl #(
  parameter int N        = 4,
  parameter int PRESCALE = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         btn_step,
  input  logic [N-1:0] gray_in,
  input  logic         target_en,
  input  logic [N-1:0] target,
  output logic         clk_en,
  output logic         running,
  output logic         done
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  localparam int B_STEP  = 0;
  localparam int B_START = 1;
  localparam int B_STOP  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync2_q, prev_q;
  logic [2:0]       pulse;
  logic             stop_cmd, start_cmd, step_cmd;
  logic             match;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign btn_raw = {btn_stop, btn_start, btn_step};

  // Two-flop synchronizer plus an edge register gives one pulse per press.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

  // Only the highest-priority command present acts: stop > start > step.
  assign stop_cmd  = pulse[B_STOP];
  assign start_cmd = pulse[B_START] & ~pulse[B_STOP];
  assign step_cmd  = pulse[B_STEP] & ~pulse[B_START] & ~pulse[B_STOP];

  assign match = target_en && (gray2bin(gray_in) == target);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_en_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_cmd) begin
          state_d = ST_RUN;
        end else if (step_cmd) begin
          clk_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (match) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d = '0;
        if (stop_cmd || start_cmd) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clk_en  = clk_en_q;
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule
